gate_truth_checker: RTL

Self-contained sequencer/checker wrapped around the two-input `LogicGates` stage. It drives `a`/`b` through all four input combinations and samples the seven gate outputs after a programmable settle time. It compares each sample against the expected truth table and reports a pass flag, a saturating mismatch count and a sticky per-gate failure mask. It sits directly upstream of the gate stage, supplying its inputs, and directly downstream of it, consuming `y1..y7`. It is used as the on-chip self-test for that stage.

---
 rtl/gate_chk_pkg.sv | 48 ++++
 rtl/gate_truth_checker_expected.sv | 16 +
 rtl/gate_truth_checker.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/gate_chk_pkg.sv
// -----------------------------------------------------------------------------
// gate_chk_pkg
// Shared types and constants for the gate-stage self-test checker.
//   state_e      : checker FSM states
//   *_IDX        : bit position of each gate output inside the 7-bit y bus
//   EXP_TABLE    : expected y[6:0] for each {a,b} vector, indexed by vector
//   popcount7()  : number of set bits in a 7-bit value
// -----------------------------------------------------------------------------
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int N_GATES  = 7;
  localparam int AND_IDX  = 0;
  localparam int OR_IDX   = 1;
  localparam int NOT_IDX  = 2;  // NOT of input a
  localparam int NAND_IDX = 3;
  localparam int NOR_IDX  = 4;
  localparam int XOR_IDX  = 5;
  localparam int XNOR_IDX = 6;

  // Element [v] is the expected y[6:0] for {a,b} = v.
  //   00 : XNOR NOR NAND NOT          -> 1011100
  //   01 : XOR NAND NOT OR (NOR = 0)  -> 0101110
  //   10 : XOR NAND OR                -> 0101010
  //   11 : XNOR OR AND                -> 1000011
  localparam logic [3:0][N_GATES-1:0] EXP_TABLE = {
    7'b1000011,   // [3] {a,b}=11
    7'b0101010,   // [2] {a,b}=10
    7'b0101110,   // [1] {a,b}=01
    7'b1011100    // [0] {a,b}=00
  };

  function automatic logic [2:0] popcount7(input logic [N_GATES-1:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < N_GATES; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/gate_truth_checker_expected.sv
// -----------------------------------------------------------------------------
// gate_expected
// Combinational truth-table lookup for the two-input gate stage.
//   vec_i [1:0] : vector index, equal to {a,b}
//   exp_o [6:0] : expected gate outputs y[6:0] for that vector
// -----------------------------------------------------------------------------
module gate_expected
  import gate_chk_pkg::*;
(
  input  logic [1:0]         vec_i,
  output logic [N_GATES-1:0] exp_o
);

  assign exp_o = EXP_TABLE[vec_i];

endmodule

// File: rtl/gate_truth_checker.sv
// -----------------------------------------------------------------------------
// gate_truth_checker
// On-chip self-test sequencer for the two-input LogicGates stage. Walks {a,b}
// through 00,01,10,11, holds each vector SETTLE_CYCLES cycles plus one sample
// cycle, compares y against the expected truth table and accumulates results.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : begin one pass (accepted only while idle)
//   a, b       : registered gate inputs
//   y [6:0]    : gate outputs (y[0]=AND .. y[6]=XNOR)
//   busy       : pass in progress, through the done cycle
//   done       : one-cycle end-of-pass pulse
//   pass       : last completed pass had no mismatches
//   err_count  : saturating count of mismatched output bits
//   fail_mask  : sticky per-gate mismatch flags
// -----------------------------------------------------------------------------
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               a,
  output logic               b,
  input  logic [N_GATES-1:0] y,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [N_GATES-1:0] fail_mask
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_e             state_q;
  logic [1:0]         vec_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               a_q;
  logic               b_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [ERR_W-1:0]   err_q;
  logic [ERR_W-1:0]   err_d;
  logic [N_GATES-1:0] mask_q;
  logic [N_GATES-1:0] exp_y;
  logic [N_GATES-1:0] mis;
  logic [1:0]         vec_nxt;
  logic [ERR_W:0]     err_sum;

  gate_expected u_expected (
    .vec_i (vec_q),
    .exp_o (exp_y)
  );

  assign mis     = y ^ exp_y;
  assign vec_nxt = vec_q + 2'd1;

  // One extra carry bit is enough: ERR_W >= 3 and at most 7 bits are added.
  always_comb begin
    err_sum = {1'b0, err_q} + {{(ERR_W-2){1'b0}}, popcount7(mis)};
    err_d   = err_sum[ERR_W] ? ERR_MAX : err_sum[ERR_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      mask_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            err_q   <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
            vec_q   <= 2'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_SAMPLE: begin
          mask_q <= mask_q | mis;
          err_q  <= err_d;
          if (vec_q == 2'd3) begin
            // err_q still excludes this final sample, so fold mis in here to
            // have pass valid alongside done.
            pass_q  <= (err_q == '0) && (mis == '0);
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            vec_q   <= vec_nxt;
            a_q     <= vec_nxt[1];
            b_q     <= vec_nxt[0];
            cnt_q   <= CNT_LOAD;
            state_q <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule
